// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data-memory controller for the MEM stage.
// Accepts one word-aligned load or store, holds the pipeline for LATENCY
// wait states, then answers with a one-cycle ack (plus data_valid for loads).
// Optional feature macro: DMEM_RANGE_CHECK_EN adds an err output that flags
// addresses with nonzero bits above the RAM index range.
module dmem_ctrl #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        stall,
    output logic        data_valid,
    output logic [31:0] rdata,
    output logic        ack
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [3:0]          cnt_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [31:0]         wdata_reg;
    logic [3:0]          mask_reg;
    logic                err_reg;
    logic                addr_oob;
    logic [3:0]          lane_we;
    logic                unused_addr_bits;

    logic [31:0] mem [DEPTH];

    // Out-of-range detection only exists with the range check; otherwise
    // upper address bits silently alias.
`ifdef DMEM_RANGE_CHECK_EN
    assign addr_oob = |req_addr[31:ADDR_W+2];
`else
    assign addr_oob = 1'b0;
`endif

    // Byte offset and upper bits are deliberately ignored by the index.
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // State register plus the request copy latched at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= 32'd0;
            mask_reg  <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        idx_reg   <= req_addr[ADDR_W+1:2];
                        wdata_reg <= req_wdata;
                        mask_reg  <= req_mask;
                        err_reg   <= addr_oob;
                        cnt_reg   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic: RESP always returns to IDLE so a request still held
    // during RESP is not accepted a second time.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = WAIT;
            WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; reset suppresses every pulse, including an in-flight ack.
    always_comb begin
        stall      = 1'b0;
        ack        = 1'b0;
        data_valid = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        err        = 1'b0;
`endif
        if (!rst) begin
            case (state_reg)
                IDLE: stall = req_valid;
                WAIT: stall = 1'b1;
                RESP: begin
                    ack        = 1'b1;
                    data_valid = !we_reg;
`ifdef DMEM_RANGE_CHECK_EN
                    err        = err_reg;
`endif
                end
                default: ;
            endcase
        end
    end

    // Per-lane write enables; stores commit on the RESP->IDLE edge only.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
        assign lane_we[gi] = (state_reg == RESP) && we_reg && mask_reg[gi]
                             && !err_reg && !rst;
    end

    // Byte-enabled RAM write port.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[idx_reg][8*b +: 8] <= wdata_reg[8*b +: 8];
            end
        end
    end

    // Registered read on the WAIT->RESP edge; rdata holds between loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (state_reg == WAIT && cnt_reg == 4'd0 && !we_reg) begin
            rdata <= err_reg ? 32'd0 : mem[idx_reg];
        end
    end

endmodule
